// File: rtl/test_ctrl_pkg.sv
// Shared types and default parameters for the test_ctrl bench sequencer.
// Optional stall watchdog is enabled by defining TEST_CTRL_STALL_WATCHDOG_EN.
package test_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_RUN   = 3'd2,
        ST_PASS  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_CHECK,
        CAUSE_TIMEOUT,
        CAUSE_STALL
    } fail_cause_t;

    localparam int DEFAULT_RESET_CYCLES = 3;
    localparam int DEFAULT_TIMEOUT      = 10000;
    localparam int DEFAULT_STALL_LIMIT  = 256;

endpackage

// File: rtl/test_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset, synchronous clear and count enable.
module test_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/test_ctrl.sv
// Bench sequencer: owns DUT reset, run-cycle counting and a latched pass/fail verdict.
// Define TEST_CTRL_STALL_WATCHDOG_EN to add the no-progress stall watchdog.
module test_ctrl
    import test_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
    parameter int TIMEOUT      = DEFAULT_TIMEOUT,
    parameter int STALL_LIMIT  = DEFAULT_STALL_LIMIT,
    parameter int CW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          src_done,
    input  logic          sink_done,
    input  logic          progress,
    input  logic          check_fail,
    output logic          dut_rst,
    output logic          run,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic          stall,
    output logic [CW-1:0] cycles,
    output logic [CW-1:0] fail_cycle,
    output logic [2:0]    state
);

    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_t      cur_state, next_state;
    fail_cause_t cause;
    logic [RW-1:0] rst_cnt;
    logic          reset_last, timeout_hit, stall_hit;
    logic          dut_rst_d, run_d, done_d, pass_d, timeout_d;
    logic [CW-1:0] fail_cycle_d;

    assign state       = cur_state;
    assign reset_last  = (rst_cnt == RW'(RESET_CYCLES - 1));
    assign timeout_hit = (TIMEOUT != 0) && (cycles == CW'(TIMEOUT));

    test_ctrl_sat_counter #(.W(RW)) u_reset_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cur_state != ST_RESET),
        .en    (cur_state == ST_RESET),
        .count (rst_cnt)
    );

    // Cleared when a new test is launched; does not advance on the edge that leaves RUN, so it freezes.
    test_ctrl_sat_counter #(.W(CW)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (next_state == ST_RESET),
        .en    ((cur_state == ST_RUN) && (next_state == ST_RUN)),
        .count (cycles)
    );

`ifdef TEST_CTRL_STALL_WATCHDOG_EN
    logic [CW-1:0] stall_cnt;
    logic          stall_d;

    test_ctrl_sat_counter #(.W(CW)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   ((cur_state != ST_RUN) || progress),
        .en    (cur_state == ST_RUN),
        .count (stall_cnt)
    );

    // The current idle cycle counts too, so the limit fires on the STALL_LIMIT-th idle cycle.
    assign stall_hit = !progress && (stall_cnt >= CW'(STALL_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall <= 1'b0;
        end else begin
            stall <= stall_d;
        end
    end
`else
    logic unused_progress;
    localparam logic unused_stall_limit = (STALL_LIMIT >= 1);

    assign unused_progress = progress;
    assign stall_hit       = 1'b0;
    assign stall           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= ST_IDLE;
            dut_rst    <= 1'b1;
            run        <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            fail_cycle <= '0;
        end else begin
            cur_state  <= next_state;
            dut_rst    <= dut_rst_d;
            run        <= run_d;
            done       <= done_d;
            pass       <= pass_d;
            timeout    <= timeout_d;
            fail_cycle <= fail_cycle_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        next_state = cur_state;
        cause      = CAUSE_NONE;
        case (cur_state)
            ST_IDLE:  if (start) next_state = ST_RESET;
            ST_RESET: if (reset_last) next_state = ST_RUN;
            ST_RUN: begin
                if (check_fail) begin
                    next_state = ST_FAIL;
                    cause      = CAUSE_CHECK;
                end else if (src_done && sink_done) begin
                    next_state = ST_PASS;
                end else if (timeout_hit) begin
                    next_state = ST_FAIL;
                    cause      = CAUSE_TIMEOUT;
                end else if (stall_hit) begin
                    next_state = ST_FAIL;
                    cause      = CAUSE_STALL;
                end
            end
            ST_PASS, ST_FAIL: if (start) next_state = ST_RESET;
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered alongside the state itself.
    always_comb begin
        dut_rst_d    = (next_state == ST_IDLE) || (next_state == ST_RESET);
        run_d        = (next_state == ST_RUN);
        done_d       = (next_state == ST_PASS) || (next_state == ST_FAIL);
        pass_d       = (next_state == ST_PASS);
        timeout_d    = timeout;
        fail_cycle_d = fail_cycle;
`ifdef TEST_CTRL_STALL_WATCHDOG_EN
        stall_d      = stall;
`endif
        if (next_state == ST_RESET) begin
            timeout_d    = 1'b0;
            fail_cycle_d = '0;
`ifdef TEST_CTRL_STALL_WATCHDOG_EN
            stall_d      = 1'b0;
`endif
        end else if ((cur_state == ST_RUN) && (next_state == ST_FAIL)) begin
            timeout_d    = (cause == CAUSE_TIMEOUT);
            fail_cycle_d = cycles;
`ifdef TEST_CTRL_STALL_WATCHDOG_EN
            stall_d      = (cause == CAUSE_STALL);
`endif
        end
    end

endmodule

// File: tb/tb_test_ctrl.sv
// Self-checking bench for test_ctrl: scenario table with a scoreboard plus multi-cycle corner sequences.
// Expectations follow TEST_CTRL_STALL_WATCHDOG_EN when it is defined for the build.
module tb_test_ctrl;
    import test_ctrl_pkg::*;

    localparam int RC     = 3;
    localparam int TO     = 50;
    localparam int SL     = 4;
    localparam int CW     = 32;
    localparam int BUDGET = TO + 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_b, start, src_done, sink_done, progress, check_fail;
    logic dut_rst, run, done, pass, timeout, stall;
    logic [CW-1:0] cycles, fail_cycle;
    logic [2:0] state;
    logic nt_dut_rst, nt_run, nt_done, nt_pass, nt_timeout, nt_stall;
    logic [CW-1:0] nt_cycles, nt_fail_cycle;
    logic [2:0] nt_state;

    test_ctrl #(.RESET_CYCLES(RC), .TIMEOUT(TO), .STALL_LIMIT(SL), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .src_done(src_done), .sink_done(sink_done),
        .progress(progress), .check_fail(check_fail), .dut_rst(dut_rst), .run(run),
        .done(done), .pass(pass), .timeout(timeout), .stall(stall), .cycles(cycles),
        .fail_cycle(fail_cycle), .state(state)
    );

    // Second instance with the global timeout disabled, held in reset until its own sequences.
    test_ctrl #(.RESET_CYCLES(RC), .TIMEOUT(0), .STALL_LIMIT(SL), .CW(CW)) dut_nt (
        .clk(clk), .rst(rst_b), .start(start), .src_done(src_done), .sink_done(sink_done),
        .progress(progress), .check_fail(check_fail), .dut_rst(nt_dut_rst), .run(nt_run),
        .done(nt_done), .pass(nt_pass), .timeout(nt_timeout), .stall(nt_stall), .cycles(nt_cycles),
        .fail_cycle(nt_fail_cycle), .state(nt_state)
    );

    typedef struct {
        string name;
        int    src_at;
        int    sink_at;
        int    fail_at;
        int    idle_from;
        logic  exp_pass;
        logic  exp_timeout;
        logic  exp_stall;
        int    exp_cycles;
        int    exp_fail_cycle;
    } vec_t;

    typedef struct {
        string      name;
        logic [2:0] state;
        logic       pass;
        logic       timeout;
        logic       stall;
        int         cycles;
        int         fail_cycle;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic clear_inputs();
        start      = 1'b0;
        src_done   = 1'b0;
        sink_done  = 1'b0;
        progress   = 1'b0;
        check_fail = 1'b0;
    endtask

    // Pulses start and checks the reset window; returns at the first RUN cycle.
    task automatic begin_test(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " state=RESET"}, state, ST_RESET);
        check({tag, " dut_rst first"}, dut_rst, 1);
        check({tag, " cycles in RESET"}, cycles, 0);
        check({tag, " fail_cycle cleared"}, fail_cycle, 0);
        check({tag, " pass cleared"}, pass, 0);
        check({tag, " done cleared"}, done, 0);
        check({tag, " timeout cleared"}, timeout, 0);
        check({tag, " stall cleared"}, stall, 0);
        repeat (RC - 1) @(negedge clk);
        check({tag, " dut_rst last"}, dut_rst, 1);
        check({tag, " run low in RESET"}, run, 0);
        @(negedge clk);
        check({tag, " run"}, run, 1);
        check({tag, " dut_rst released"}, dut_rst, 0);
        check({tag, " cycles at run start"}, cycles, 0);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   k;
        bit   finished;
        e.name       = v.name;
        e.state      = v.exp_pass ? ST_PASS : ST_FAIL;
        e.pass       = v.exp_pass;
        e.timeout    = v.exp_timeout;
        e.stall      = v.exp_stall;
        e.cycles     = v.exp_cycles;
        e.fail_cycle = v.exp_fail_cycle;
        sb.push_back(e);
        begin_test(v.name);
        k = 0;
        finished = 1'b0;
        while (!finished && k <= BUDGET) begin
            if (k == 5) check({v.name, " cycles@5"}, cycles, 5);
            src_done   = (v.src_at >= 0) && (k >= v.src_at);
            sink_done  = (v.sink_at >= 0) && (k >= v.sink_at);
            check_fail = (k == v.fail_at);
            progress   = !((v.idle_from >= 0) && (k >= v.idle_from));
            @(negedge clk);
            if (done) finished = 1'b1;
            else k++;
        end
        clear_inputs();
        e = sb.pop_front();
        if (!finished) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s budget: no verdict after %0d run cycles, expected cycles=%0d", e.name, k, e.cycles);
        end else begin
            check({e.name, " state"}, state, e.state);
            check({e.name, " pass"}, pass, e.pass);
            check({e.name, " timeout"}, timeout, e.timeout);
            check({e.name, " stall"}, stall, e.stall);
            check({e.name, " cycles"}, cycles, e.cycles);
            check({e.name, " fail_cycle"}, fail_cycle, e.fail_cycle);
            check({e.name, " run"}, run, 0);
            check({e.name, " dut_rst"}, dut_rst, 0);
            @(negedge clk);
            check({e.name, " cycles frozen"}, cycles, e.cycles);
            check({e.name, " state held"}, state, e.state);
        end
    endtask

    initial begin
        //             name            src  sink fail idle pass to   st   cyc fc
        vecs[0] = '{"pass@20",        15,  20,  -1,  -1, 1'b1, 1'b0, 1'b0, 20, 0};
        vecs[1] = '{"fail+done@7",     7,   7,   7,  -1, 1'b0, 1'b0, 1'b0,  7, 7};
        vecs[2] = '{"timeout",        -1,  -1,  -1,  -1, 1'b0, 1'b1, 1'b0, 50, 50};
`ifdef TEST_CTRL_STALL_WATCHDOG_EN
        vecs[3] = '{"stall@10",       -1,  -1,  -1,  10, 1'b0, 1'b0, 1'b1, 13, 13};
`else
        vecs[3] = '{"stall@10",       -1,  -1,  -1,  10, 1'b0, 1'b1, 1'b0, 50, 50};
`endif
        vecs[4] = '{"fail@0",         -1,  -1,   0,  -1, 1'b0, 1'b0, 1'b0,  0, 0};
        vecs[5] = '{"src_only",        0,  -1,  -1,  -1, 1'b0, 1'b1, 1'b0, 50, 50};
        vecs[6] = '{"pass@0",          0,   0,  -1,  -1, 1'b1, 1'b0, 1'b0,  0, 0};

        clear_inputs();
        rst   = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check("reset state", state, ST_IDLE);
        check("reset dut_rst", dut_rst, 1);
        check("reset run", run, 0);
        check("reset done", done, 0);
        check("reset pass", pass, 0);
        check("reset timeout", timeout, 0);
        check("reset stall", stall, 0);
        check("reset cycles", cycles, 0);
        check("reset fail_cycle", fail_cycle, 0);
        rst = 1'b0;

        check_fail = 1'b1;
        @(negedge clk);
        check_fail = 1'b0;
        check("idle check_fail ignored state", state, ST_IDLE);
        check("idle check_fail ignored done", done, 0);
        check("idle dut_rst", dut_rst, 1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Restart from PASS, ignore start during RUN, then synchronous reset at run cycle 12.
        begin_test("rst_run");
        for (int k = 0; k < 12; k++) begin
            if (k == 4) begin
                check("start ignored in RUN state", state, ST_RUN);
                check("start ignored in RUN cycles", cycles, 4);
            end
            start    = (k == 3);
            progress = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_run state", state, ST_IDLE);
        check("rst_run dut_rst", dut_rst, 1);
        check("rst_run cycles", cycles, 0);
        check("rst_run run", run, 0);

        // Reset in the middle of the RESET window.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_reset state", state, ST_IDLE);
        check("rst_reset dut_rst", dut_rst, 1);
        @(negedge clk);
        check("rst_reset stays idle", state, ST_IDLE);

        // TIMEOUT=0 instance must keep running.
        rst_b = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (RC) @(negedge clk);
        check("nt run start", nt_run, 1);
        check("nt cycles start", nt_cycles, 0);
        progress = 1'b1;
        repeat (200) @(negedge clk);
        check("nt state@200", nt_state, ST_RUN);
        check("nt cycles@200", nt_cycles, 200);
        check("nt done@200", nt_done, 0);
        check("nt timeout@200", nt_timeout, 0);

        // Stall stimulus on the no-timeout instance: watchdog fires or the test keeps running.
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (RC) @(negedge clk);
        for (int k = 0; k < 30; k++) begin
            progress = (k < 10);
            @(negedge clk);
        end
        progress = 1'b0;
`ifdef TEST_CTRL_STALL_WATCHDOG_EN
        check("nt stall state", nt_state, ST_FAIL);
        check("nt stall flag", nt_stall, 1);
        check("nt stall timeout", nt_timeout, 0);
        check("nt stall fail_cycle", nt_fail_cycle, 13);
        check("nt stall cycles", nt_cycles, 13);
`else
        check("nt nostall state", nt_state, ST_RUN);
        check("nt nostall flag", nt_stall, 0);
        check("nt nostall cycles", nt_cycles, 30);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/test_ctrl.md
# test_ctrl

Synthesizable test-harness sequencer that owns DUT reset, the run-phase cycle counter, and pass/fail/timeout decisions for NPU block benches. It sits between a bench's source/sink/checker blocks and the DUT:
- drives the DUT reset for a fixed window;
- counts run cycles;
- watches for completion, checker mismatches, global timeout and (optionally) lack of handshake progress;
- latches a single verdict.

It replaces ad-hoc behavioural timeout/reset logic so that benches behave identically in simulation and on FPGA emulation.

## Interface
- RESET_CYCLES, 3, DUT reset hold length in cycles (≥1)
- TIMEOUT, 10000, run-cycle limit; 0 disables the global timeout
- STALL_LIMIT, 256, consecutive no-progress cycles before a stall failure (≥1)
- CW, 32, width of cycle counters
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a test from IDLE, PASS or FAIL
- src_done  in  1  level; source has emitted all messages
- sink_done  in  1  level; sink has consumed all expected messages
- progress  in  1  any val&rdy handshake fired this cycle
- check_fail  in  1  checker mismatch pulse
- dut_rst  out  1  reset driven to the DUT
- run  out  1  high while in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS
- timeout  out  1  FAIL cause: global timeout
- stall  out  1  FAIL cause: stall watchdog
- cycles  out  CW  run-cycle count
- fail_cycle  out  CW  value of cycles at the failing event
- state  out  3  current FSM state encoding

## Operation
- States: IDLE, RESET, RUN, PASS, FAIL.
- On rst:
  - state=IDLE, dut_rst=1, all other outputs 0.
  - cycles=0, fail_cycle=0, internal reset and stall counters 0.
- IDLE:
  - dut_rst=1.
  - start → RESET.
- RESET:
  - dut_rst=1, cycles held at 0.
  - Internal counter runs 0..RESET_CYCLES-1, then → RUN.
  - start is ignored.
- RUN:
  - dut_rst=0, run=1.
  - cycles increments every cycle and saturates at 2^CW-1.
  - start is ignored.
  - Per-cycle priority, highest first:
    1. check_fail → FAIL; fail_cycle=cycles.
    2. src_done & sink_done → PASS.
    3. TIMEOUT≠0 and cycles==TIMEOUT → FAIL, timeout=1, fail_cycle=cycles.
    4. Stall condition (see Configuration) → FAIL, stall=1, fail_cycle=cycles.
  - A check_fail arriving in the same cycle as done yields FAIL.
- PASS / FAIL:
  - Terminal; done=1, dut_rst=0 so DUT state remains inspectable.
  - cycles is frozen.
  - start → RESET and clears pass/timeout/stall/fail_cycle/cycles.
- check_fail outside RUN is ignored.
- Status flags are mutually exclusive. timeout and stall are never both 1.

## Timing
- All outputs are registered, and all input decisions take effect on the next edge.
- start sampled at edge t:
  - RESET state visible from t+1.
  - dut_rst high for cycles t+1..t+RESET_CYCLES.
  - RUN (dut_rst=0) from t+RESET_CYCLES+1.
- In the first RUN cycle cycles=0. It reads k in the k-th subsequent cycle.
- Failing or done condition sampled at edge e: terminal state and flags visible at e+1. fail_cycle equals the cycles value present before edge e.
- rst mid-RESET or mid-RUN: next cycle is IDLE with all outputs at reset values.

## Configuration
- TEST_CTRL_STALL_WATCHDOG_EN defined:
  - Stall counter clears on progress and increments in RUN otherwise. It is cleared on entry to RUN.
  - When it reaches STALL_LIMIT with no higher-priority event → FAIL with stall=1.
- Macro undefined:
  - No stall counter is instantiated and the progress input is unused.
  - stall is tied to 0.

## Structure
- Package test_ctrl_pkg holds:
  - state enum (IDLE=0, RESET=1, RUN=2, PASS=3, FAIL=4);
  - default constants for RESET_CYCLES, TIMEOUT and STALL_LIMIT.
- One natural sub-module: test_ctrl_sat_counter, a saturating up-counter with synchronous clear and enable. It is instantiated for cycles, for the reset counter and, under the macro, for the stall counter.
- FSM and verdict registers live in test_ctrl.

## Test plan
- RESET_CYCLES=3, start pulse at t → dut_rst=1 for t+1..t+3, run=1 at t+4, cycles=0 at t+4, cycles=5 at t+9.
- src_done=1, then sink_done=1 at run cycle 20 → pass=1, done=1 next cycle, cycles frozen at 20, timeout=stall=0.
- check_fail and both done inputs asserted together at run cycle 7 → FAIL, fail_cycle=7, pass=0.
- TIMEOUT=50, no done inputs, progress=1 every cycle → FAIL with timeout=1, fail_cycle=50. With TIMEOUT=0 still RUN after 200 cycles.
- Macro defined, STALL_LIMIT=4, progress=1 until run cycle 10, then 0 → stall=1, FAIL entered after the 4th idle cycle. Macro undefined: same stimulus stays in RUN.
- rst asserted at run cycle 12 → IDLE next cycle, dut_rst=1, cycles=0. A second start after PASS clears pass and restarts the RESET window.
